tmds_pipe_encoder: RTL and testbench
====================================

TMDS_PIPE_ENCODER -- requirements
Module: tmds_pipe_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of independent TMDS channels (1..8).
REQ-002 SHALL have parameter DISP_W, default 5, signed running-disparity width per channel (minimum 5).
REQ-003 SHALL use one clock and a synchronous, active-low reset: clk_in  input  1  rising-edge clock for all state.
REQ-004 rst_n_in  input  1  synchronous active-low reset, sampled on clk_in.
REQ-005 mode_in  input  2  period type: 00 control, 01 video, 10 video guard band, 11 data island.
REQ-006 data_in  input  8*NUM_CH  video byte per channel; channel k at bits [8k+7:8k].
REQ-007 control_in  input  2*NUM_CH  control bits {c1,c0} per channel; blue carries {vs,hs}.
REQ-008 terc4_in  input  4*NUM_CH  data-island nibble per channel.
REQ-009 tmds_out  output  10*NUM_CH  encoded symbol per channel, registered.
REQ-010 disparity_out  output  DISP_W*NUM_CH  signed running disparity per channel after the symbol on tmds_out.
REQ-011 valid_out  output  1  high once the pipeline holds post-reset samples.

Function
REQ-012 SHALL have a fixed latency of 2 cycles: inputs sampled at edge N appear on tmds_out after edge N+2.
REQ-013 Stage 1 SHALL register the 9-bit transition-minimised word q_m, its ones count, the mode and the control/TERC4 inputs per channel.
REQ-014 q_m SHALL use XNOR chaining when ones(data)>4, or ones==4 with data[0]==0, else XOR; q_m[8]=1 for XOR, 0 for XNOR.
REQ-015 Stage 2 in video mode SHALL apply DVI 1.0 DC balancing: with disparity==0 or ones==zeros, out={~q_m8,q_m8,q_m8?q_m[7:0]:~q_m[7:0]}.
REQ-016 Otherwise SHALL invert (bit9=1) when (disp>0 and ones>zeros) or (disp<0 and zeros>ones), disp += 2*q_m8 + zeros - ones; else bit9=0, disp += ones - zeros - 2*~q_m8.
REQ-017 Disparity arithmetic SHALL be signed DISP_W two's complement, wrapping without saturation.
REQ-018 Control mode SHALL output 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011 (bit 9 first listed).
REQ-019 Guard-band mode SHALL output 1011001100 on channels with k mod 3 in {0,2} and 0100110011 on k mod 3 == 1.
REQ-020 Any non-video mode in stage 2 SHALL clear that channel's disparity to 0 in the same cycle.
REQ-021 Mode SHALL travel with its data through the pipeline; a mode change takes effect exactly on the symbol of the sample it accompanied, with no merged or dropped symbols.
REQ-022 All channels SHALL be encoded independently and in lockstep; no channel shall affect another's disparity.

Reset
REQ-023 While rst_n_in==0 at an edge: tmds_out=0, disparity_out=0, valid_out=0, all pipeline registers 0.
REQ-024 After release, valid_out SHALL rise on the second edge; reset asserted mid-stream SHALL discard both in-flight samples.

Configuration
REQ-025 Macro TMDS_PIPE_TERC4_EN defined: mode 11 SHALL output the HDMI 1.4 TERC4 code for terc4_in (e.g. 0000->1010011100, 0001->1001100011).
REQ-026 Macro undefined: mode 11 SHALL behave as control mode using control_in; terc4_in is ignored and no TERC4 table is synthesised.

Structure
REQ-027 Package tmds_pkg SHALL hold the mode enum, the four control codes, the two guard-band codes and the 16-entry TERC4 table.
REQ-028 Stage 1 SHALL be a sub-module tmds_tm_stage (one channel, registered q_m and ones count), instantiated NUM_CH times.

Verification
REQ-029 Reset then control mode, ch0 control_in=00 for 3 cycles -> valid_out low 2 edges, then ch0 tmds_out=1101010100, disparity 0.
REQ-030 Video, disparity 0, data 0x00 twice -> 0100000000 (disp -8), then 1111111111 (disp +2).
REQ-031 Guard band, NUM_CH=3 -> ch0 1011001100, ch1 0100110011, ch2 1011001100.
REQ-032 Mode 11, terc4_in 0000 all channels -> 1010011100 with macro; control code per control_in without macro.
REQ-033 Video 0x00 then one control cycle then video 0x00 -> disparity_out 0 after control; second video symbol 0100000000.
REQ-034 Reset asserted for one cycle mid video stream -> outputs 0, valid_out low, next two outputs reflect only post-reset inputs.

Source files
------------

// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the pipelined TMDS encoder: period-type enum, the four
// control-period symbols, the two video guard-band symbols and the HDMI TERC4
// table. Symbols are written bit 9 first (MSB on the left).
// The TERC4 table is only referenced when TMDS_PIPE_TERC4_EN is defined.
// -----------------------------------------------------------------------------
package tmds_pkg;

   typedef enum logic [1:0] {
      MODE_CTRL   = 2'b00,
      MODE_VIDEO  = 2'b01,
      MODE_GUARD  = 2'b10,
      MODE_ISLAND = 2'b11
   } tmds_mode_e;

   // Indexed by {c1,c0}
   localparam logic [9:0] CTRL_CODE [4] = '{
      10'b1101010100,
      10'b0010101011,
      10'b0101010100,
      10'b1010101011
   };

   // Guard band: channels 0 and 2 (mod 3) use GUARD_CODE_0, channel 1 uses GUARD_CODE_1
   localparam logic [9:0] GUARD_CODE_0 = 10'b1011001100;
   localparam logic [9:0] GUARD_CODE_1 = 10'b0100110011;

   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

endpackage

// File: rtl/tmds_tm_stage.sv
// -----------------------------------------------------------------------------
// tmds_tm_stage
// Stage 1 of the TMDS pipeline for one channel: transition-minimised word q_m
// and the number of ones in q_m[7:0], both registered.
// Ports:
//   clk_i    rising-edge clock
//   rst_n_i  synchronous active-low reset
//   data_i   video byte
//   q_m_o    registered 9-bit transition-minimised word
//   ones_o   registered ones count of q_m[7:0] (0..8)
// -----------------------------------------------------------------------------
module tmds_tm_stage
   import tmds_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] data_i,
   output logic [8:0] q_m_o,
   output logic [3:0] ones_o
);

   logic [8:0] q_m_d, q_m_q;
   logic [3:0] ones_d, ones_q;
   logic [3:0] data_ones;
   logic       use_xnor;

   always_comb begin
      data_ones = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         data_ones = data_ones + {3'b000, data_i[i]};
      end
      use_xnor = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data_i[0]);

      q_m_d    = '0;
      q_m_d[0] = data_i[0];
      for (int unsigned i = 1; i < 8; i++) begin
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_i[i]) : (q_m_d[i-1] ^ data_i[i]);
      end
      q_m_d[8] = ~use_xnor;

      ones_d = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         ones_d = ones_d + {3'b000, q_m_d[i]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         q_m_q  <= '0;
         ones_q <= '0;
      end else begin
         q_m_q  <= q_m_d;
         ones_q <= ones_d;
      end
   end

   assign q_m_o  = q_m_q;
   assign ones_o = ones_q;

endmodule

// File: rtl/tmds_pipe_encoder.sv
// -----------------------------------------------------------------------------
// tmds_pipe_encoder
// Two-stage pipelined multi-channel TMDS encoder (DVI 1.0 video coding with DC
// balancing, control symbols, guard band, optional HDMI TERC4 data island).
// Optional feature: define TMDS_PIPE_TERC4_EN to encode mode 11 as TERC4 from
// terc4_in; otherwise mode 11 emits control symbols from control_in.
// Ports:
//   clk_in         rising-edge clock
//   rst_n_in       synchronous active-low reset
//   mode_in        00 control, 01 video, 10 guard band, 11 data island
//   data_in        video byte per channel, channel k at [8k+7:8k]
//   control_in     {c1,c0} per channel
//   terc4_in       data-island nibble per channel
//   tmds_out       registered 10-bit symbol per channel
//   disparity_out  signed running disparity per channel after tmds_out symbol
//   valid_out      high once the output stage holds a post-reset sample
// -----------------------------------------------------------------------------
module tmds_pipe_encoder
   import tmds_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DISP_W = 5
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [1:0]                 mode_in,
   input  logic [8*NUM_CH-1:0]        data_in,
   input  logic [2*NUM_CH-1:0]        control_in,
   input  logic [4*NUM_CH-1:0]        terc4_in,
   output logic [10*NUM_CH-1:0]       tmds_out,
   output logic [DISP_W*NUM_CH-1:0]   disparity_out,
   output logic                       valid_out
);

   localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

   // Stage 1 side-band registers travelling with q_m
   tmds_mode_e          mode_q;
   logic [2*NUM_CH-1:0] ctrl_q;
   logic                v1_q, v2_q;

`ifdef TMDS_PIPE_TERC4_EN
   logic [4*NUM_CH-1:0] terc4_q;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) terc4_q <= '0;
      else           terc4_q <= terc4_in;
   end
`else
   logic unused_terc4;
   assign unused_terc4 = ^terc4_in;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         mode_q <= MODE_CTRL;
         ctrl_q <= '0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
      end else begin
         mode_q <= tmds_mode_e'(mode_in);
         ctrl_q <= control_in;
         v1_q   <= 1'b1;
         v2_q   <= v1_q;
      end
   end

   assign valid_out = v2_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [8:0]               q_m;
      logic [3:0]               ones;
      logic [9:0]               tmds_d, tmds_q;
      logic signed [DISP_W-1:0] disp_d, disp_q;
      logic signed [DISP_W-1:0] bal;

      tmds_tm_stage u_tm (
         .clk_i   (clk_in),
         .rst_n_i (rst_n_in),
         .data_i  (data_in[8*k +: 8]),
         .q_m_o   (q_m),
         .ones_o  (ones)
      );

      always_comb begin
         tmds_d = '0;
         disp_d = '0;
         // ones - zeros of q_m[7:0], i.e. 2*ones - 8
         bal    = DISP_W'({1'b0, ones, 1'b0}) - DISP_W'(8);
         // An empty stage 1 (just out of reset) leaves the output stage cleared
         if (v1_q) begin
            case (mode_q)
               MODE_VIDEO: begin
                  if ((disp_q == '0) || (ones == 4'd4)) begin
                     tmds_d = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
                     disp_d = q_m[8] ? (disp_q + bal) : (disp_q - bal);
                  end else if ((!disp_q[DISP_W-1] && (ones > 4'd4)) ||
                               ( disp_q[DISP_W-1] && (ones < 4'd4))) begin
                     tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
                     disp_d = disp_q - bal + (q_m[8] ? TWO : '0);
                  end else begin
                     tmds_d = {1'b0, q_m[8], q_m[7:0]};
                     disp_d = disp_q + bal - (q_m[8] ? '0 : TWO);
                  end
               end
               MODE_GUARD: begin
                  tmds_d = ((k % 3) == 1) ? GUARD_CODE_1 : GUARD_CODE_0;
               end
`ifdef TMDS_PIPE_TERC4_EN
               MODE_ISLAND: begin
                  tmds_d = TERC4_TABLE[terc4_q[4*k +: 4]];
               end
`endif
               default: begin
                  tmds_d = CTRL_CODE[ctrl_q[2*k +: 2]];
               end
            endcase
         end
      end

      always_ff @(posedge clk_in) begin
         if (!rst_n_in) begin
            tmds_q <= '0;
            disp_q <= '0;
         end else begin
            tmds_q <= tmds_d;
            disp_q <= disp_d;
         end
      end

      assign tmds_out[10*k +: 10]               = tmds_q;
      assign disparity_out[DISP_W*k +: DISP_W] = disp_q;
   end

endmodule

// File: tb/tb_tmds_pipe_encoder.sv
`timescale 1ns/1ps
module tb_tmds_pipe_encoder;

   localparam int NUM_CH = 3;
   localparam int DISP_W = 5;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic [1:0]                mode;
   logic [8*NUM_CH-1:0]       data;
   logic [2*NUM_CH-1:0]       ctrl;
   logic [4*NUM_CH-1:0]       terc4;
   logic [10*NUM_CH-1:0]      tmds_out;
   logic [DISP_W*NUM_CH-1:0]  disparity_out;
   logic                      valid_out;

   always #5 clk = ~clk;

   tmds_pipe_encoder #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .mode_in       (mode),
      .data_in       (data),
      .control_in    (ctrl),
      .terc4_in      (terc4),
      .tmds_out      (tmds_out),
      .disparity_out (disparity_out),
      .valid_out     (valid_out)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
      end
   endtask

   function automatic int tm(input int ch);
      logic [9:0] v;
      v = tmds_out[10*ch +: 10];
      return int'(v);
   endfunction

   function automatic int dsp(input int ch);
      logic signed [DISP_W-1:0] v;
      v = disparity_out[DISP_W*ch +: DISP_W];
      return int'(v);
   endfunction

   // ---------------- reference symbol tables ----------------
   int CTRL_T [4]   = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   int TERC_T [16]  = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
   int GB_02 = 10'b1011001100;
   int GB_1  = 10'b0100110011;

   function automatic int wrap(input int d);
      int w, v;
      w = 1 << DISP_W;
      v = ((d % w) + w) % w;
      if (v >= w / 2) v = v - w;
      return v;
   endfunction

   // Video symbol from the DVI rules: q_m bit i is the parity of d[i:0],
   // with odd bits flipped when the XNOR variant is selected.
   function automatic int enc_video(input logic [7:0] d, input int disp_in, output int disp_out);
      int  n1, ones, zeros, q8, qi, qn, sym, disp, mask;
      bit  xn;
      logic [7:0] q;
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      for (int i = 0; i < 8; i++) begin
         mask = (1 << (i + 1)) - 1;
         q[i] = (^(int'(d) & mask)) ^ (xn && (i % 2 == 1));
      end
      q8    = xn ? 0 : 1;
      qi    = int'(q);
      qn    = 255 - qi;
      ones  = $countones(q);
      zeros = 8 - ones;
      disp  = disp_in;
      if (disp == 0 || ones == zeros) begin
         sym  = (q8 ? 0 : 512) + q8 * 256 + (q8 ? qi : qn);
         disp = disp + (q8 ? (ones - zeros) : (zeros - ones));
      end else if ((disp > 0 && ones > zeros) || (disp < 0 && zeros > ones)) begin
         sym  = 512 + q8 * 256 + qn;
         disp = disp + 2 * q8 + zeros - ones;
      end else begin
         sym  = q8 * 256 + qi;
         disp = disp + ones - zeros - 2 * (1 - q8);
      end
      disp_out = wrap(disp);
      return sym;
   endfunction

   // ---------------- behavioural model ----------------
   bit                  p1_v = 1'b0;
   logic [1:0]          p1_mode;
   logic [8*NUM_CH-1:0] p1_data;
   logic [2*NUM_CH-1:0] p1_ctrl;
   logic [4*NUM_CH-1:0] p1_terc;
   int                  m_disp [NUM_CH];
   int                  e_tmds [NUM_CH];
   int                  e_disp [NUM_CH];
   bit                  e_v = 1'b0;
   bit                  done = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         p1_v = 1'b0;
         e_v  = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_disp[c] = 0; e_tmds[c] = 0; e_disp[c] = 0;
         end
      end else begin
         e_v = p1_v;
         for (int c = 0; c < NUM_CH; c++) begin
            if (p1_v) begin
               case (p1_mode)
                  2'b01: e_tmds[c] = enc_video(p1_data[8*c +: 8], m_disp[c], m_disp[c]);
                  2'b10: begin e_tmds[c] = (c % 3 == 1) ? GB_1 : GB_02; m_disp[c] = 0; end
`ifdef TMDS_PIPE_TERC4_EN
                  2'b11: begin e_tmds[c] = TERC_T[p1_terc[4*c +: 4]]; m_disp[c] = 0; end
`endif
                  default: begin e_tmds[c] = CTRL_T[p1_ctrl[2*c +: 2]]; m_disp[c] = 0; end
               endcase
            end else begin
               m_disp[c] = 0;
            end
            e_disp[c] = m_disp[c];
         end
         p1_v    = 1'b1;
         p1_mode = mode;
         p1_data = data;
         p1_ctrl = ctrl;
         p1_terc = terc4;
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (!done) begin
         chk("valid", int'(valid_out), int'(e_v));
         if (e_v) begin
            for (int c = 0; c < NUM_CH; c++) begin
               chk($sformatf("model_tmds[%0d]", c), tm(c), e_tmds[c]);
               chk($sformatf("model_disp[%0d]", c), dsp(c), e_disp[c]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic r, input logic [1:0] m, input logic [7:0] d,
                      input logic [2*NUM_CH-1:0] c, input logic [3:0] t);
      #1;
      rst_n = r;
      mode  = m;
      data  = {NUM_CH{d}};
      ctrl  = c;
      terc4 = {NUM_CH{t}};
   endtask

   // ---------------- directed literal checks, then random traffic ----------------
   initial begin
      rst_n = 1'b0; mode = 2'b00; data = '0; ctrl = '0; terc4 = '0;
      repeat (3) step();
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_tmds", int'(tmds_out), 0);
      chk("rst_disp", int'(disparity_out), 0);

      drv(1'b1, 2'b00, 8'h00, '0, 4'h0);
      step();                                      // E1
      chk("e1_valid_low", int'(valid_out), 0);
      step();                                      // E2
      chk("e2_valid_high", int'(valid_out), 1);
      chk("e2_ctrl00", tm(0), 10'b1101010100);
      chk("e2_disp0", dsp(0), 0);
      drv(1'b1, 2'b01, 8'h00, '0, 4'h0);
      step();                                      // E3
      chk("e3_ctrl00", tm(0), 10'b1101010100);
      step();                                      // E4
      chk("e4_vid00_first", tm(0), 10'b0100000000);
      chk("e4_disp_m8", dsp(0), -8);
      drv(1'b1, 2'b00, 8'h00, '0, 4'h0);
      step();                                      // E5
      chk("e5_vid00_second", tm(0), 10'b1111111111);
      chk("e5_disp_p2", dsp(0), 2);
      drv(1'b1, 2'b01, 8'h00, '0, 4'h0);
      step();                                      // E6
      chk("e6_ctrl_disp_clear", dsp(0), 0);
      chk("e6_ctrl_sym", tm(0), 10'b1101010100);
      drv(1'b1, 2'b10, 8'h00, '0, 4'h0);
      step();                                      // E7
      chk("e7_vid_after_ctrl", tm(0), 10'b0100000000);
      chk("e7_disp_m8", dsp(0), -8);
      drv(1'b1, 2'b11, 8'h00, {2'b11, 2'b10, 2'b01}, 4'h0);
      step();                                      // E8
      chk("guard_ch0", tm(0), 10'b1011001100);
      chk("guard_ch1", tm(1), 10'b0100110011);
      chk("guard_ch2", tm(2), 10'b1011001100);
      chk("guard_disp0", dsp(0), 0);
      drv(1'b1, 2'b01, 8'hFF, '0, 4'h0);
      step();                                      // E9
`ifdef TMDS_PIPE_TERC4_EN
      chk("island_ch0", tm(0), 10'b1010011100);
      chk("island_ch1", tm(1), 10'b1010011100);
      chk("island_ch2", tm(2), 10'b1010011100);
`else
      chk("island_ch0", tm(0), 10'b0010101011);
      chk("island_ch1", tm(1), 10'b0101010100);
      chk("island_ch2", tm(2), 10'b1010101011);
`endif
      drv(1'b0, 2'b01, 8'hFF, '0, 4'h0);
      step();                                      // E10: reset edge
      chk("midrst_valid", int'(valid_out), 0);
      chk("midrst_tmds", int'(tmds_out), 0);
      chk("midrst_disp", int'(disparity_out), 0);
      drv(1'b1, 2'b01, 8'h00, '0, 4'h0);
      step();                                      // E11
      chk("postrst_valid_low", int'(valid_out), 0);
      step();                                      // E12
      chk("postrst_valid_high", int'(valid_out), 1);
      chk("postrst_vid00", tm(0), 10'b0100000000);
      chk("postrst_disp_m8", dsp(0), -8);

      for (int n = 0; n < 3000; n++) begin
         int r;
         #1;
         rst_n = ($urandom_range(0, 63) != 0);
         r     = $urandom_range(0, 9);
         mode  = (r < 6) ? 2'b01 : 2'($urandom_range(0, 3));
         data  = (8*NUM_CH)'($urandom());
         ctrl  = (2*NUM_CH)'($urandom());
         terc4 = (4*NUM_CH)'($urandom());
         step();
      end

      @(negedge clk);
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
